// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes, SR/Cause bit positions.
package cp0_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned IDX_W = 5;

   localparam logic [IDX_W-1:0] REG_COUNT   = 5'd9;
   localparam logic [IDX_W-1:0] REG_COMPARE = 5'd11;
   localparam logic [IDX_W-1:0] REG_SR      = 5'd12;
   localparam logic [IDX_W-1:0] REG_CAUSE   = 5'd13;
   localparam logic [IDX_W-1:0] REG_EPC     = 5'd14;
   localparam logic [IDX_W-1:0] REG_PRID    = 5'd15;

   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

   localparam logic [XLEN-1:0] HANDLER_ADDR = 32'h0000_4180;

   localparam int unsigned SR_IE_BIT    = 0;
   localparam int unsigned SR_EXL_BIT   = 1;
   localparam int unsigned SR_IM_LO     = 10;
   localparam int unsigned SR_IM_HI     = 15;
   localparam int unsigned CAUSE_BD_BIT = 31;
   localparam int unsigned CAUSE_IP_LO  = 10;
   localparam int unsigned CAUSE_IP_HI  = 15;
   localparam int unsigned CAUSE_EXC_LO = 2;
   localparam int unsigned CAUSE_EXC_HI = 6;

   typedef struct packed {
      logic [5:0] im;
      logic       exl;
      logic       ie;
   } sr_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a pending flag that feeds interrupt line IP[15].
module cp0_timer
   import cp0_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [IDX_W-1:0] addr,
   input  logic [XLEN-1:0]  wdata,
   output logic [XLEN-1:0]  count,
   output logic [XLEN-1:0]  compare,
   output logic             pend
);

   logic [XLEN-1:0] count_q, count_d;
   logic [XLEN-1:0] compare_q, compare_d;
   logic            pend_q, pend_d;

   // A Compare write acknowledges the timer, so its clear beats a same-cycle match.
   always_comb begin
      count_d   = count_q + XLEN'(1);
      compare_d = compare_q;
      pend_d    = pend_q | (count_q == compare_q);
      if (we && (addr == REG_COUNT)) begin
         count_d = wdata;
      end
      if (we && (addr == REG_COMPARE)) begin
         compare_d = wdata;
         pend_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         compare_q <= '0;
         pend_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         pend_q    <= pend_d;
      end
   end

   assign count   = count_q;
   assign compare = compare_q;
   assign pend    = pend_q;

endmodule

// File: rtl/cp0.sv
// CP0 exception/interrupt controller at the M stage; holds SR, Cause, EPC, PRId.
// Optional Count/Compare timer enabled by defining CP0_COUNT_EN.
module cp0
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] Din,
   input  logic        We,
   input  logic [31:0] PC_M,
   input  logic        BD_M,
   input  logic [4:0]  Exc_Code_M,
   input  logic        EXLClr,
   input  logic [5:0]  HWInt,
   output logic [31:0] Dout,
   output logic [31:0] EPC_out,
   output logic        Req
);

   sr_t             sr_q, sr_d;
   logic            bd_q, bd_d;
   logic [5:0]      ip_q, ip_d;
   logic [4:0]      exc_q, exc_d;
   logic [XLEN-1:0] epc_q, epc_d;

   logic            timer_pend;
   logic [5:0]      ip_now;
   logic            int_req;
   logic            exc_req;
   logic            wr_en;

`ifdef CP0_COUNT_EN
   logic [XLEN-1:0] count_val;
   logic [XLEN-1:0] compare_val;

   cp0_timer u_timer (
      .clk     (clk),
      .rst_n   (reset),
      .we      (wr_en),
      .addr    (A2),
      .wdata   (Din),
      .count   (count_val),
      .compare (compare_val),
      .pend    (timer_pend)
   );
`else
   assign timer_pend = 1'b0;
`endif

   // Request logic uses live HWInt so the flush lands in the same cycle.
   always_comb begin
      ip_now  = {HWInt[5] | timer_pend, HWInt[4:0]};
      int_req = sr_q.ie & ~sr_q.exl & (|(ip_now & sr_q.im));
      exc_req = ~sr_q.exl & (Exc_Code_M != 5'd0);
      Req     = reset & (int_req | exc_req);
      wr_en   = We & ~Req;
   end

   always_comb begin
      sr_d  = sr_q;
      bd_d  = bd_q;
      ip_d  = ip_now;
      exc_d = exc_q;
      epc_d = epc_q;
      if (wr_en && (A2 == REG_SR)) begin
         sr_d.im  = Din[SR_IM_HI:SR_IM_LO];
         sr_d.exl = Din[SR_EXL_BIT];
         sr_d.ie  = Din[SR_IE_BIT];
      end
      if (wr_en && (A2 == REG_EPC)) begin
         epc_d = word_align(Din);
      end
      if (EXLClr) begin
         sr_d.exl = 1'b0;
      end
      if (Req) begin
         sr_d.exl = 1'b1;
         bd_d     = BD_M;
         exc_d    = int_req ? EXC_INT : Exc_Code_M;
         epc_d    = BD_M ? word_align(PC_M - XLEN'(4)) : word_align(PC_M);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q  <= '0;
         bd_q  <= 1'b0;
         ip_q  <= '0;
         exc_q <= '0;
         epc_q <= '0;
      end else begin
         sr_q  <= sr_d;
         bd_q  <= bd_d;
         ip_q  <= ip_d;
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

   always_comb begin
      Dout = '0;
      case (A1)
         REG_SR:    Dout = {16'd0, sr_q.im, 8'd0, sr_q.exl, sr_q.ie};
         REG_CAUSE: Dout = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'b00};
         REG_EPC:   Dout = epc_q;
         REG_PRID:  Dout = PRID_VALUE;
`ifdef CP0_COUNT_EN
         REG_COUNT:   Dout = count_val;
         REG_COMPARE: Dout = compare_val;
`endif
         default:   Dout = '0;
      endcase
   end

   // Forward an in-flight EPC write so eret in the same cycle sees it.
   always_comb begin
      EPC_out = epc_q;
      if (reset && We && (A2 == REG_EPC)) begin
         EPC_out = word_align(Din);
      end
   end

endmodule

// File: tb/tb_cp0.sv
// Scoreboard bench for cp0: stimulus queues expectations, a negedge monitor checks them.
module tb_cp0;

   logic        clk;
   logic        reset;
   logic [4:0]  A1, A2;
   logic [31:0] Din;
   logic        We;
   logic [31:0] PC_M;
   logic        BD_M;
   logic [4:0]  Exc_Code_M;
   logic        EXLClr;
   logic [5:0]  HWInt;
   logic [31:0] Dout, EPC_out;
   logic        Req;

   localparam int SEL_DOUT = 0;
   localparam int SEL_EPC  = 1;
   localparam int SEL_REQ  = 2;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   cp0 dut (
      .clk        (clk),
      .reset      (reset),
      .A1         (A1),
      .A2         (A2),
      .Din        (Din),
      .We         (We),
      .PC_M       (PC_M),
      .BD_M       (BD_M),
      .Exc_Code_M (Exc_Code_M),
      .EXLClr     (EXLClr),
      .HWInt      (HWInt),
      .Dout       (Dout),
      .EPC_out    (EPC_out),
      .Req        (Req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: outputs are presented for checking at each falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         e = sb.pop_front();
         case (e.sel)
            SEL_DOUT: act = Dout;
            SEL_EPC:  act = EPC_out;
            default:  act = {31'd0, Req};
         endcase
         n_cmp++;
         if (act !== e.val) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input int sel, input logic [31:0] val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic rd(input string name, input logic [4:0] idx, input logic [31:0] val);
      A1 = idx;
      expect_out(name, SEL_DOUT, val);
      tick();
   endtask

   task automatic mtc0(input logic [4:0] idx, input logic [31:0] data);
      A2  = idx;
      Din = data;
      We  = 1'b1;
      tick();
      We  = 1'b0;
   endtask

   initial begin
      reset = 1'b0; A1 = '0; A2 = '0; Din = '0; We = 1'b0; PC_M = '0;
      BD_M = 1'b0; Exc_Code_M = 5'd12; EXLClr = 1'b0; HWInt = '0;
      tick();
      // Held in reset with a live exception code and an EPC write.
      expect_out("reset_req", SEL_REQ, 32'd0);
      rd("reset_sr", 5'd12, 32'd0);
      rd("reset_cause", 5'd13, 32'd0);
      We = 1'b1; A2 = 5'd14; Din = 32'h0000_1234;
      expect_out("reset_epc_out", SEL_EPC, 32'd0);
      rd("reset_epc", 5'd14, 32'd0);
      We = 1'b0;

      Exc_Code_M = 5'd0;
      reset = 1'b1;
      expect_out("post_reset_req", SEL_REQ, 32'd0);
      rd("post_reset_cause", 5'd13, 32'd0);
`ifdef CP0_COUNT_EN
      mtc0(5'd11, 32'hFFFF_0000);
`endif

      // Overflow in a delay slot.
      PC_M = 32'h0000_3008; BD_M = 1'b1; Exc_Code_M = 5'd12;
      expect_out("exc_req", SEL_REQ, 32'd1);
      tick();
      BD_M = 1'b0; Exc_Code_M = 5'd0;
      rd("exc_epc", 5'd14, 32'h0000_3004);
      rd("exc_cause", 5'd13, 32'h8000_0030);
      rd("exc_sr_exl", 5'd12, 32'h0000_0002);
      Exc_Code_M = 5'd4;
      expect_out("exl_masks_req", SEL_REQ, 32'd0);
      tick();
      Exc_Code_M = 5'd0;
      rd("exl_cause_hold", 5'd13, 32'h8000_0030);

      EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;
      rd("exlclr_sr", 5'd12, 32'd0);

      // Interrupt beats a simultaneous RI.
      mtc0(5'd12, 32'h0000_0401);
      HWInt = 6'b000001; Exc_Code_M = 5'd10; PC_M = 32'h0000_3100;
      expect_out("int_req", SEL_REQ, 32'd1);
      tick();
      HWInt = '0; Exc_Code_M = 5'd0;
      rd("int_cause", 5'd13, 32'h0000_0400);
      rd("int_epc", 5'd14, 32'h0000_3100);
      rd("int_sr", 5'd12, 32'h0000_0403);

      // eret with an interrupt still pending: Req follows the next cycle.
      HWInt = 6'b000001; EXLClr = 1'b1;
      expect_out("eret_req_masked", SEL_REQ, 32'd0);
      tick();
      EXLClr = 1'b0; PC_M = 32'h0000_3200;
      expect_out("eret_then_int", SEL_REQ, 32'd1);
      tick();
      rd("eret_int_epc", 5'd14, 32'h0000_3200);

      // IM=0: interrupt ignored, RI taken.
      mtc0(5'd12, 32'h0000_0001);
      expect_out("im0_no_req", SEL_REQ, 32'd0);
      tick();
      Exc_Code_M = 5'd10; PC_M = 32'h0000_3300;
      expect_out("im0_ri_req", SEL_REQ, 32'd1);
      tick();
      Exc_Code_M = 5'd0; HWInt = '0;
      rd("im0_ri_cause", 5'd13, 32'h0000_0428);

      EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;

      // EPC forwarding and write-vs-Req collision.
      We = 1'b1; A2 = 5'd14; Din = 32'h0000_3011;
      expect_out("epc_fwd", SEL_EPC, 32'h0000_3010);
      tick();
      We = 1'b0;
      rd("epc_written", 5'd14, 32'h0000_3010);
      We = 1'b1; A2 = 5'd14; Din = 32'h0000_5555;
      Exc_Code_M = 5'd8; PC_M = 32'h0000_3404;
      expect_out("collide_req", SEL_REQ, 32'd1);
      expect_out("collide_fwd", SEL_EPC, 32'h0000_5554);
      tick();
      We = 1'b0; Exc_Code_M = 5'd0;
      rd("collide_epc", 5'd14, 32'h0000_3404);

      mtc0(5'd13, 32'hFFFF_FFFF);
      rd("cause_readonly", 5'd13, 32'h0000_0020);

      // Read of SR during its own write returns the old value.
      A1 = 5'd12; A2 = 5'd12; Din = 32'h0000_0C01; We = 1'b1;
      expect_out("sr_no_fwd", SEL_DOUT, 32'h0000_0003);
      tick();
      We = 1'b0;
      rd("sr_new", 5'd12, 32'h0000_0C01);

`ifndef CP0_COUNT_EN
      mtc0(5'd11, 32'h0000_1234);
      rd("unmapped_11", 5'd11, 32'd0);
      rd("unmapped_9", 5'd9, 32'd0);
`else
      mtc0(5'd12, 32'd0);
      mtc0(5'd9, 32'd0);
      mtc0(5'd11, 32'd5);
      mtc0(5'd12, 32'h0000_8001);
      for (int i = 0; i < 4; i++) begin
         expect_out("timer_wait", SEL_REQ, 32'd0);
         tick();
      end
      expect_out("timer_req", SEL_REQ, 32'd1);
      tick();
      mtc0(5'd11, 32'd100);
      mtc0(5'd12, 32'h0000_8001);
      expect_out("timer_cleared", SEL_REQ, 32'd0);
      rd("compare_rd", 5'd11, 32'd100);
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd("count_max", 5'd9, 32'hFFFF_FFFF);
      rd("count_wrap", 5'd9, 32'd0);
`endif

      rd("prid", 5'd15, 32'd0);
      tick();
      tick();
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
